// File: rtl/rv32i_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_bus_responder
//  Description : Bridges RV32I load/store requests (byte/half/word, any
//                XLEN >= 32) onto a 16-bit synchronous memory port. Word
//                accesses take two halfword beats. Byte/half loads are
//                sign- or zero-extended. Illegal requests complete at once
//                with an error flag and no memory traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module rv32i_bus_responder #(
  parameter int XLEN          = 32,
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  // core-side request
  input  logic [XLEN-1:0]          req_addr_i,
  input  logic                     req_read_i,
  input  logic                     req_write_i,
  input  logic [2:0]               req_size_i,
  input  logic [XLEN-1:0]          req_wdata_i,
  output logic                     req_ready_o,
  // core-side response
  output logic                     resp_valid_o,
  output logic [XLEN-1:0]          resp_rdata_o,
  output logic                     resp_err_o,
  // 16-bit synchronous memory port
  output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
  output logic                     mem_rd_o,
  output logic                     mem_wr_o,
  output logic [15:0]              mem_wdata_o,
  output logic [1:0]               mem_wmask_o,
  input  logic [15:0]              mem_rdata_i
);

  // Access size encodings carried in funct3[1:0].
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LO   = 3'd1,
    RD_HI   = 3'd2,
    RD_WAIT = 3'd3,
    WR_LO   = 3'd4,
    WR_HI   = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  // Request fields captured at acceptance. Only the byte offset and the
  // halfword address bits are kept; higher address bits never reach memory.
  logic [MEM_ADDR_BITS:0]   lat_addr;
  logic [2:0]               lat_size;
  logic [31:0]              lat_wdata;
  logic                     lat_write;
  logic                     lat_err;

  // Halfwords returned by the memory for the current load.
  logic [15:0]              rd_lo;
  logic [15:0]              rd_hi;

  logic                     req_any;
  logic                     req_err;
  logic                     accept;
  logic                     is_word;
  logic                     capture_lo;
  logic                     capture_hi;
  logic [MEM_ADDR_BITS-1:0] base_addr;
  logic [MEM_ADDR_BITS-1:0] next_addr;
  logic [7:0]               load_byte;
  logic [XLEN-1:0]          load_result;

  // Address bits above the memory window are deliberately discarded.
  logic                     unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[XLEN-1:MEM_ADDR_BITS+1];

  assign req_any   = req_read_i | req_write_i;
  assign accept    = (state == IDLE) && req_any;
  assign is_word   = (lat_size[1:0] == SZ_WORD);
  assign base_addr = lat_addr[MEM_ADDR_BITS:1];
  // Second beat of a word access wraps naturally at the window top.
  assign next_addr = base_addr + MEM_ADDR_BITS'(1);

  // The low half arrives the cycle after the first strobe: in RD_HI for a
  // word, in RD_WAIT otherwise. The high half always arrives in RD_WAIT.
  assign capture_lo = (state == RD_HI) || ((state == RD_WAIT) && !is_word);
  assign capture_hi = (state == RD_WAIT) && is_word;

  // Decode illegal request combinations presented in IDLE.
  always_comb begin
    req_err = 1'b0;
    if (req_read_i && req_write_i) begin
      req_err = 1'b1;
    end
    if (req_size_i[1:0] == 2'b11) begin
      req_err = 1'b1;
    end
    if ((req_size_i[1:0] == SZ_WORD) && req_size_i[2]) begin
      req_err = 1'b1;
    end
    if (req_write_i && req_size_i[2]) begin
      req_err = 1'b1;
    end
    if ((req_size_i[1:0] == SZ_HALF) && req_addr_i[0]) begin
      req_err = 1'b1;
    end
    if ((req_size_i[1:0] == SZ_WORD) && (req_addr_i[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state sequencing for the read, write and error paths.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (req_err) begin
            state_nxt = RESP;
          end else if (req_read_i) begin
            state_nxt = RD_LO;
          end else begin
            state_nxt = WR_LO;
          end
        end
      end
      RD_LO:   state_nxt = is_word ? RD_HI : RD_WAIT;
      RD_HI:   state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RESP;
      WR_LO:   state_nxt = is_word ? WR_HI : RESP;
      WR_HI:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on acceptance and read-data capture per beat.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      rd_lo     <= '0;
      rd_hi     <= '0;
    end else begin
      if (accept) begin
        lat_addr  <= req_addr_i[MEM_ADDR_BITS:0];
        lat_size  <= req_size_i;
        lat_wdata <= req_wdata_i[31:0];
        lat_write <= req_write_i;
        lat_err   <= req_err;
      end
      if (capture_lo) begin
        rd_lo <= mem_rdata_i;
      end
      if (capture_hi) begin
        rd_hi <= mem_rdata_i;
      end
    end
  end

  // Load alignment and extension from the captured halfwords.
  always_comb begin
    load_byte   = lat_addr[0] ? rd_lo[15:8] : rd_lo[7:0];
    load_result = '0;
    case (lat_size[1:0])
      SZ_BYTE: begin
        if (lat_size[2]) begin
          load_result = XLEN'(load_byte);
        end else begin
          load_result = XLEN'($signed(load_byte));
        end
      end
      SZ_HALF: begin
        if (lat_size[2]) begin
          load_result = XLEN'(rd_lo);
        end else begin
          load_result = XLEN'($signed(rd_lo));
        end
      end
      SZ_WORD: load_result = XLEN'($signed({rd_hi, rd_lo}));
      default: load_result = '0;
    endcase
  end

  // Moore outputs: memory strobes per beat and the one-cycle response.
  always_comb begin
    req_ready_o  = (state == IDLE);
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_rdata_o = '0;
    mem_addr_o   = '0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    mem_wdata_o  = '0;
    mem_wmask_o  = 2'b00;
    case (state)
      RD_LO: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = base_addr;
      end
      RD_HI: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = next_addr;
      end
      WR_LO: begin
        mem_wr_o   = 1'b1;
        mem_addr_o = base_addr;
        if (lat_size[1:0] == SZ_BYTE) begin
          // Byte is replicated on both lanes; the mask picks the lane.
          mem_wdata_o = {lat_wdata[7:0], lat_wdata[7:0]};
          mem_wmask_o = lat_addr[0] ? 2'b10 : 2'b01;
        end else begin
          mem_wdata_o = lat_wdata[15:0];
          mem_wmask_o = 2'b11;
        end
      end
      WR_HI: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = next_addr;
        mem_wdata_o = lat_wdata[31:16];
        mem_wmask_o = 2'b11;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = lat_err;
        if (!lat_err && !lat_write) begin
          resp_rdata_o = load_result;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_bus_responder
//  Description : Self-checking bench for rv32i_bus_responder. A 16-bit
//                synchronous memory model serves the DUT; a byte-addressed
//                reference memory predicts load data, strobes and latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32i_bus_responder;

  localparam int XLEN    = 32;
  localparam int MAB     = 16;
  localparam int HWORDS  = 1 << MAB;
  localparam int BYTES   = 2 * HWORDS;
  localparam int TIMEOUT = 12;

  typedef struct {
    bit          wr;
    int unsigned addr;
    int unsigned data;
    int unsigned mask;
  } strobe_t;

  logic            clk       = 1'b0;
  logic            reset_n   = 1'b0;
  logic [XLEN-1:0] req_addr  = '0;
  logic            req_read  = 1'b0;
  logic            req_write = 1'b0;
  logic [2:0]      req_size  = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [MAB-1:0]  mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [15:0]     mem_wdata;
  logic [1:0]      mem_wmask;
  logic [15:0]     mem_rdata = '0;

  logic [15:0]     hmem [HWORDS];
  logic [7:0]      bmem [BYTES];

  int              errors     = 0;
  int              checks     = 0;
  int              proto_viol = 0;
  int              resp_cnt   = 0;
  strobe_t         obs_q[$];

  always #5 clk = ~clk;

  rv32i_bus_responder #(
    .XLEN          (XLEN),
    .MEM_ADDR_BITS (MAB)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .req_addr_i   (req_addr),
    .req_read_i   (req_read),
    .req_write_i  (req_write),
    .req_size_i   (req_size),
    .req_wdata_i  (req_wdata),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_addr_o   (mem_addr),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .mem_wdata_o  (mem_wdata),
    .mem_wmask_o  (mem_wmask),
    .mem_rdata_i  (mem_rdata)
  );

  // Synchronous 16-bit memory with per-byte write mask.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= hmem[mem_addr];
    if (mem_wr) begin
      if (mem_wmask[0]) hmem[mem_addr][7:0]  <= mem_wdata[7:0];
      if (mem_wmask[1]) hmem[mem_addr][15:8] <= mem_wdata[15:8];
    end
  end

  // Record memory strobes and port-protocol violations mid-cycle.
  always @(negedge clk) begin
    if (mem_rd || mem_wr) obs_q.push_back('{mem_wr, 32'(mem_addr), 32'(mem_wdata), 32'(mem_wmask)});
    proto_viol <= proto_viol + ((mem_rd && mem_wr) ? 1 : 0)
                             + ((!mem_wr && (mem_wmask != 2'b00 || mem_wdata != 16'h0)) ? 1 : 0);
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  function automatic logic [15:0] pat(int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  task automatic poke(input int unsigned h, input logic [15:0] v);
    hmem[h]       <= v;
    bmem[2*h]     = v[7:0];
    bmem[2*h + 1] = v[15:8];
  endtask

  // Legality of a request from the load/store rules, byte address a.
  function automatic bit model_err(bit rd, bit wr, int unsigned a, logic [2:0] size);
    if (rd && wr) return 1'b1;
    case (size[1:0])
      2'b00:   return wr && size[2];
      2'b01:   return (wr && size[2]) || (a % 2 != 0);
      2'b10:   return size[2] || (a % 4 != 0);
      default: return 1'b1;
    endcase
  endfunction

  // One complete transaction with full prediction and checking.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] got_rdata, output logic got_err);
    int unsigned a, n, beats, hw, ba, idx, exp_lat, lat;
    int          viol0;
    bit          exp_err, done;
    logic [31:0] exp_rdata;
    strobe_t     exp_q[$];
    strobe_t     s;
    a         = addr % BYTES;
    n         = 1 << size[1:0];
    exp_err   = model_err(rd, wr, a, size);
    exp_rdata = '0;
    if (!exp_err && rd) begin
      for (int k = 0; k < int'(n); k++) exp_rdata |= 32'(bmem[(a + k) % BYTES]) << (8 * k);
      if (!size[2] && n < 4 && exp_rdata[8*n-1]) exp_rdata |= ~((32'd1 << (8 * n)) - 32'd1);
    end
    beats = exp_err ? 0 : ((n == 4) ? 2 : 1);
    for (int k = 0; k < int'(beats); k++) begin
      hw     = ((a / 2) + k) % HWORDS;
      s.wr   = wr;
      s.addr = hw;
      s.data = 0;
      s.mask = 0;
      if (wr) begin
        for (int j = 0; j < 2; j++) begin
          ba  = 2 * hw + j;
          idx = (ba + BYTES - a) % BYTES;
          if (idx < n) begin
            s.mask |= 1 << j;
            s.data |= 32'(wd[8*idx +: 8]) << (8 * j);
          end else begin
            s.data |= 32'(wd[7:0]) << (8 * j);
          end
        end
      end
      exp_q.push_back(s);
    end
    exp_lat = exp_err ? 1 : beats + (rd ? 2 : 1);

    @(negedge clk);
    obs_q.delete();
    viol0     = proto_viol;
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", tag, req_ready);
    end
    @(posedge clk);
    #1;
    // Junk on the request lines while busy must be ignored.
    req_read  = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_size  = 3'($urandom);
    req_wdata = $urandom;
    lat  = 1;
    done = 0;
    while (!done && lat <= TIMEOUT) begin
      @(negedge clk);
      if (resp_valid === 1'b1) done = 1;
      else lat++;
    end
    req_read  = 1'b0;
    req_write = 1'b0;
    got_rdata = resp_rdata;
    got_err   = resp_err;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid within %0d cycles", tag, TIMEOUT);
    end else begin
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
      end
      checks++;
      if (resp_err !== exp_err) begin
        errors++;
        $display("FAIL %s err: got %b want %b", tag, resp_err, exp_err);
      end
      checks++;
      if (resp_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL %s rdata: got %h want %h", tag, resp_rdata, exp_rdata);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL %s strobe count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i].wr != exp_q[i].wr || obs_q[i].addr != exp_q[i].addr ||
              obs_q[i].data != exp_q[i].data || obs_q[i].mask != exp_q[i].mask) begin
            errors++;
            $display("FAIL %s beat%0d: got wr=%0d a=%h d=%h m=%0d want wr=%0d a=%h d=%h m=%0d", tag, i,
                     obs_q[i].wr, obs_q[i].addr, obs_q[i].data, obs_q[i].mask,
                     exp_q[i].wr, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || proto_viol != viol0) begin
      errors++;
      $display("FAIL %s after-resp: valid=%b ready=%b viol=%0d want 0 1 %0d", tag, resp_valid, req_ready, proto_viol, viol0);
    end
    if (!exp_err && wr) begin
      for (int k = 0; k < int'(n); k++) bmem[(a + k) % BYTES] = wd[8*k +: 8];
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset ready: got %b want 1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0) begin
      errors++;
      $display("FAIL reset resp: got v=%b e=%b d=%h want 0 0 0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== '0) begin
      errors++;
      $display("FAIL reset mem: got rd=%b wr=%b a=%h d=%h m=%b want all 0", mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask);
    end
    req_read = 1'b1;
    req_addr = 32'h104;
    req_size = 3'b010;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset hold: got rd=%b valid=%b want 0 0", mem_rd, resp_valid);
    end
    req_read = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_word_read();
    logic [31:0] r;
    logic        e;
    poke(32'h82, 16'h5678);
    poke(32'h83, 16'h1234);
    do_req(1, 0, 32'h0000_0104, 3'b010, 32'h0, "lw_104", r, e);
    checks++;
    if (r !== 32'h1234_5678 || e !== 1'b0) begin
      errors++;
      $display("FAIL lw_104 value: got %h err=%b want 12345678 err=0", r, e);
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] r;
    logic        e;
    poke(32'h08, 16'h80AA);
    do_req(1, 0, 32'h0000_0011, 3'b000, 32'h0, "lb_11", r, e);
    checks++;
    if (r !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_11 value: got %h want ffffff80", r);
    end
    do_req(1, 0, 32'h0000_0011, 3'b100, 32'h0, "lbu_11", r, e);
    checks++;
    if (r !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_11 value: got %h want 00000080", r);
    end
  endtask

  task automatic test_stores();
    logic [31:0] r;
    logic        e;
    logic [7:0]  lo_before;
    lo_before = bmem[2];
    do_req(0, 1, 32'h0000_0003, 3'b000, 32'h0000_00A5, "sb_3", r, e);
    checks++;
    if (hmem[1] !== {8'hA5, lo_before} || r !== '0) begin
      errors++;
      $display("FAIL sb_3 mem: got %h rdata=%h want %h rdata=0", hmem[1], r, {8'hA5, lo_before});
    end
    do_req(0, 1, 32'h0000_0000, 3'b010, 32'hDEAD_BEEF, "sw_0", r, e);
    checks++;
    if (hmem[0] !== 16'hBEEF || hmem[1] !== 16'hDEAD) begin
      errors++;
      $display("FAIL sw_0 mem: got %h %h want beef dead", hmem[0], hmem[1]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] r;
    logic        e;
    poke(32'hFFFE, 16'h3333);
    poke(32'hFFFF, 16'h4444);
    do_req(1, 0, 32'h0001_FFFC, 3'b010, 32'h0, "lw_top", r, e);
    checks++;
    if (r !== 32'h4444_3333) begin
      errors++;
      $display("FAIL lw_top value: got %h want 44443333", r);
    end
    do_req(1, 0, 32'h0001_FFFE, 3'b010, 32'h0, "lw_mis", r, e);
    checks++;
    if (e !== 1'b1 || r !== '0) begin
      errors++;
      $display("FAIL lw_mis err: got err=%b rdata=%h want 1 0", e, r);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r;
    logic        e;
    do_req(1, 0, 32'h0000_0002, 3'b010, 32'h0, "lw_2", r, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL lw_2 err: got %b want 1", e);
    end
    do_req(1, 0, 32'h0000_0000, 3'b011, 32'h0, "size3", r, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL size3 err: got %b want 1", e);
    end
    do_req(1, 1, 32'h0000_0000, 3'b000, 32'h55, "rdwr", r, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL rdwr err: got %b want 1", e);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r;
    logic        e;
    int          rc0;
    @(negedge clk);
    req_read = 1'b1;
    req_addr = 32'h0000_0104;
    req_size = 3'b010;
    @(posedge clk);
    #1;
    req_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0083) begin
      errors++;
      $display("FAIL mid rd_hi: got rd=%b a=%h want 1 0083", mem_rd, mem_addr);
    end
    rc0     = resp_cnt;
    reset_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0 ||
        mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== '0) begin
      errors++;
      $display("FAIL mid reset outputs: got rdy=%b v=%b rd=%b a=%h want 1 0 0 0", req_ready, resp_valid, mem_rd, mem_addr);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_cnt != rc0) begin
      errors++;
      $display("FAIL mid no-resp: got %0d responses want 0", resp_cnt - rc0);
    end
    do_req(1, 0, 32'h0000_0104, 3'b010, 32'h0, "lw_after_rst", r, e);
    checks++;
    if (r !== 32'h1234_5678 || e !== 1'b0) begin
      errors++;
      $display("FAIL lw_after_rst value: got %h err=%b want 12345678 0", r, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, unused_rdata;
    logic [2:0]  size;
    logic        unused_err;
    int          sel, code;
    bit          rd, wr;
    for (int t = 0; t < 300; t++) begin
      sel  = $urandom_range(0, 19);
      rd   = (sel < 9) || (sel >= 18);
      wr   = (sel >= 9);
      addr = ($urandom & 32'hFFFE_0000) |
             (($urandom_range(0, 1) == 1 ? 32'h0001_FFC0 : 32'h0000_0100) + 32'($urandom_range(0, 63)));
      sel  = $urandom_range(0, 9);
      code = (sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
      size = {($urandom_range(0, 3) == 0), 2'(code)};
      if ($urandom_range(0, 4) != 0) begin
        if (code == 1) addr[0] = 1'b0;
        if (code == 2) addr[1:0] = 2'b00;
      end
      wd = $urandom;
      do_req(rd, wr, addr, size, wd, "rand", unused_rdata, unused_err);
    end
  endtask

  initial begin
    for (int i = 0; i < HWORDS; i++) begin
      hmem[i]       <= pat(i);
      bmem[2*i]     = pat(i)[7:0];
      bmem[2*i + 1] = pat(i)[15:8];
    end
    test_reset();
    test_word_read();
    test_byte_loads();
    test_stores();
    test_wrap();
    test_errors();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32i_bus_responder.md
RV32I_BUS_RESPONDER -- requirements
Module: rv32i_bus_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the core-side request/response.
REQ-002 SHALL have parameter MEM_ADDR_BITS, default 16, halfword-address width of the 16-bit memory port.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_addr_i  input  XLEN  byte address of the request.
REQ-006 SHALL have ports req_read_i and req_write_i, each input 1, load or store request.
REQ-007 SHALL have port req_size_i  input  3  funct3 of the load/store: [1:0] 00 byte, 01 half, 10 word; [2] unsigned load.
REQ-008 SHALL have port req_wdata_i  input  XLEN  store data, right-aligned.
REQ-009 SHALL have port req_ready_o  output  1  request accepted this cycle if req_read_i or req_write_i is high.
REQ-010 SHALL have ports resp_valid_o (1), resp_rdata_o (XLEN) and resp_err_o (1), all outputs: completion pulse, load result, error flag.
REQ-011 SHALL have ports mem_addr_o (MEM_ADDR_BITS), mem_rd_o (1), mem_wr_o (1), mem_wdata_o (16) and mem_wmask_o (2), all outputs to synchronous memory.
REQ-012 SHALL have port mem_rdata_i  input  16  read data, valid the cycle after mem_rd_o.

Function
REQ-013 SHALL implement FSM states IDLE, RD_LO, RD_HI, RD_WAIT, WR_LO, WR_HI, RESP; req_ready_o = 1 only in IDLE.
REQ-014 SHALL latch addr, size, wdata and direction on acceptance; inputs are ignored outside IDLE.
REQ-015 SHALL flag an error: read and write both high; size[1:0]=11; word with size[2]=1; store with size[2]=1; half with addr[0]=1; word with addr[1:0]!=0.
REQ-016 On an error it SHALL go IDLE->RESP with no memory strobe, resp_err_o=1, resp_rdata_o=0.
REQ-017 Base halfword address SHALL be addr[MEM_ADDR_BITS:1]; the second beat SHALL use base+1, wrapping modulo 2^MEM_ADDR_BITS; higher address bits are ignored.
REQ-018 Read sequence SHALL be RD_LO (mem_rd_o=1, base) -> RD_WAIT for byte/half; for word, RD_LO -> RD_HI (mem_rd_o=1, base+1) -> RD_WAIT; RD_WAIT -> RESP.
REQ-019 It SHALL capture mem_rdata_i at the end of each cycle following a mem_rd_o cycle: first beat as low half, second as high half.
REQ-020 Load result: byte = addr[0] ? low[15:8] : low[7:0]; half = low; word = {high, low}. It SHALL sign-extend byte/half unless size[2]=1, then zero-extend.
REQ-021 Write sequence SHALL be WR_LO -> RESP for byte/half and WR_LO -> WR_HI -> RESP for word, with mem_wr_o=1 in each WR state.
REQ-022 Byte write: mem_wdata_o = {wdata[7:0], wdata[7:0]}, mem_wmask_o = addr[0] ? 10 : 01.
REQ-023 Half write: wdata[15:0], mask 11. Word write: WR_LO drives wdata[15:0] at base; WR_HI drives wdata[31:16] at base+1; mask 11.
REQ-024 RESP SHALL assert resp_valid_o for exactly one cycle, then return to IDLE; resp_rdata_o = 0 for stores.
REQ-025 Latency from accept edge to resp_valid_o high: byte/half read 3 cycles, word read 4, byte/half write 2, word write 3, error 1.
REQ-026 mem_rd_o and mem_wr_o SHALL never be high together; mem_wmask_o = 00 and mem_wdata_o = 0 when mem_wr_o=0.

Reset
REQ-027 While reset_ni=0 it SHALL force state IDLE, req_ready_o=1, every other output 0 and all latched registers 0; any in-flight access is abandoned without a response.
REQ-028 It SHALL accept a request in the first clock after reset_ni deasserts.

Verification
REQ-029 Word read at 0x0000_0104, mem[0x82]=0x5678, mem[0x83]=0x1234 -> mem_rd_o at 0x82 then 0x83; resp_rdata_o=0x1234_5678 four cycles after accept.
REQ-030 LB (size 000) at 0x0000_0011, mem[0x08]=0x80AA -> 0xFFFF_FF80; LBU (size 100) -> 0x0000_0080; 3-cycle latency.
REQ-031 SB 0xA5 at 0x0000_0003 -> one mem_wr_o, addr 0x01, wdata 0xA5A5, mask 10; SW 0xDEAD_BEEF at 0x0 -> 0xBEEF at 0x0 then 0xDEAD at 0x1.
REQ-032 Word read at 0x0001_FFFC -> beats at 0xFFFE then 0xFFFF; a word read at 0x0001_FFFE is an error.
REQ-033 LW at 0x2 and size 011 -> resp_err_o=1 one cycle after accept, no memory strobe; read+write together -> error.
REQ-034 reset_ni low during RD_HI -> outputs zero immediately, no resp_valid_o; the request issued after release completes normally.
